// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM encoding and parity helper for the PS/2 receiver.
package ps2_pkg;

    localparam int FRAME_BITS     = 11;
    localparam int START_BIT      = 0;
    localparam int PARITY_BIT     = 9;
    localparam int STOP_BIT       = 10;
    localparam int MOUSE_SYNC_BIT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BITS = 1'b1
    } frameState_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS2Clk pin and debounces it; the level only follows the pin
// after FILT_LEN consecutive disagreeing samples.
module ps2_clk_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic ps2Clk_i,
    output logic filt_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILT_LEN);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q;
    logic          toggle;

    // The count restarts whenever a sample agrees with the current level, so
    // short glitches never accumulate enough to flip it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        toggle = 1'b0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                toggle = 1'b1;
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ps2Clk_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= toggle & filt_q;
        end
    end

    assign filt_o = filt_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receiver: validates 11-bit frames and assembles WORDS_PER_PKT
// bytes into a packet presented on a valid/ready handshake.
module ps2_packet_rx
    import ps2_pkg::*;
#(
    parameter int WORDS_PER_PKT = 4,
    parameter int FILT_LEN      = 4,
    parameter int TIMEOUT_CYC   = 20000,
    parameter bit ALIGN_CHECK   = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_ps2_clk,
    input  logic                       i_ps2_data,
    output logic [8*WORDS_PER_PKT-1:0] o_pkt,
    output logic                       o_pkt_valid,
    input  logic                       i_pkt_ready,
    output logic                       o_frame_err,
    output logic                       o_overrun
);

    localparam int PW  = 8 * WORDS_PER_PKT;
    localparam int WIW = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
    localparam int BCW = $clog2(FRAME_BITS);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    frameState_t    state_q, state_d;
    logic [BCW-1:0] bitCnt_q, bitCnt_d;
    logic [8:0]     shift_q, shift_d;
    logic [WIW-1:0] wordIdx_q, wordIdx_d;
    logic [TW-1:0]  toCnt_q, toCnt_d;
    logic [PW-1:0]  asm_q, asm_d;
    logic [PW-1:0]  pkt_q, pkt_d;
    logic           valid_q, valid_d;
    logic           frameErr_q, overrun_q, overrun_d;
    logic [1:0]     dataSync_q;
    logic           filtClk, filtPrev_q, fall, anyEdge, dataBit;
    logic           shiftEn, stopSample, frameOk, alignBad, goodByte, badFrame;
    logic           lastWord, complete, abandon, accept;
    int             slotBase;

    ps2_clk_filter #(.FILT_LEN(FILT_LEN)) u_clkFilter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .ps2Clk_i (i_ps2_clk),
        .filt_o   (filtClk),
        .fall_o   (fall)
    );

    assign dataBit = dataSync_q[1];
    assign anyEdge = filtClk ^ filtPrev_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
        end
    end

    // A falling edge always wins over the timeout, so a start bit arriving on
    // the saturated-counter cycle is never lost.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        if (fall) begin
            case (state_q)
                IDLE: if (dataBit == 1'(START_BIT)) begin
                    state_d  = BITS;
                    bitCnt_d = BCW'(1);
                end
                BITS: if (bitCnt_q == BCW'(STOP_BIT)) begin
                    state_d  = IDLE;
                    bitCnt_d = '0;
                end else begin
                    bitCnt_d = bitCnt_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (abandon) begin
            state_d  = IDLE;
            bitCnt_d = '0;
        end
    end

    always_comb begin
        shiftEn    = fall && (state_q == BITS) && (bitCnt_q != BCW'(STOP_BIT));
        stopSample = fall && (state_q == BITS) && (bitCnt_q == BCW'(STOP_BIT));
        frameOk    = dataBit && odd_parity_ok(shift_q[7:0], shift_q[PARITY_BIT-1]);
        alignBad   = ALIGN_CHECK && (wordIdx_q == '0) && !shift_q[MOUSE_SYNC_BIT];
        goodByte   = stopSample && frameOk && !alignBad;
        badFrame   = stopSample && !(frameOk && !alignBad);
        lastWord   = (wordIdx_q == WIW'(WORDS_PER_PKT - 1));
        complete   = goodByte && lastWord;
        abandon    = !fall && (toCnt_q == TW'(TIMEOUT_CYC)) &&
                     ((state_q == BITS) || (wordIdx_q != '0));
    end

    // Byte 0 lands in the top byte of the packet, the last byte in [7:0].
    always_comb begin
        shift_d   = shiftEn ? {dataBit, shift_q[8:1]} : shift_q;
        toCnt_d   = anyEdge ? '0 : ((toCnt_q == TW'(TIMEOUT_CYC)) ? toCnt_q : toCnt_q + 1'b1);
        wordIdx_d = wordIdx_q;
        asm_d     = asm_q;
        slotBase  = 8 * (WORDS_PER_PKT - 1 - int'(wordIdx_q));
        if (goodByte) begin
            asm_d[slotBase +: 8] = shift_q[7:0];
            wordIdx_d = lastWord ? '0 : wordIdx_q + 1'b1;
        end else if (badFrame || abandon) begin
            wordIdx_d = '0;
        end
    end

    always_comb begin
        accept    = valid_q && i_pkt_ready;
        pkt_d     = pkt_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (complete) begin
            if (valid_q && !accept) begin
                overrun_d = 1'b1;
            end else begin
                pkt_d   = asm_d;
                valid_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dataSync_q <= 2'b11;
            filtPrev_q <= 1'b1;
            shift_q    <= '0;
            wordIdx_q  <= '0;
            toCnt_q    <= '0;
            asm_q      <= '0;
            pkt_q      <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            dataSync_q <= {dataSync_q[0], i_ps2_data};
            filtPrev_q <= filtClk;
            shift_q    <= shift_d;
            wordIdx_q  <= wordIdx_d;
            toCnt_q    <= toCnt_d;
            asm_q      <= asm_d;
            pkt_q      <= pkt_d;
            valid_q    <= valid_d;
            frameErr_q <= badFrame;
            overrun_q  <= overrun_d;
        end
    end

    assign o_pkt       = pkt_q;
    assign o_pkt_valid = valid_q;
    assign o_frame_err = frameErr_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Scoreboard bench for ps2_packet_rx: a byte-level reference model queues expected
// packets and pulse counts; a negedge monitor compares whatever the DUT presents.
module tb_ps2_packet_rx;

    localparam int W    = 4;
    localparam int FILT = 4;
    localparam int TO   = 20000;

    logic        clk = 1'b0;
    logic        reset, ps2Clk, ps2Data, ready;
    logic [31:0] pkt;
    logic        valid, frameErr, overrun;

    int          checks = 0, failures = 0;
    logic [31:0] expQ[$];
    logic [7:0]  cur[$];
    bit          holding = 1'b0;
    int          errExp = 0, ovrExp = 0, errSeen = 0, ovrSeen = 0, acceptSeen = 0;
    logic [31:0] popped;

    ps2_packet_rx #(
        .WORDS_PER_PKT(W), .FILT_LEN(FILT), .TIMEOUT_CYC(TO), .ALIGN_CHECK(1'b1)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_ps2_clk   (ps2Clk),
        .i_ps2_data  (ps2Data),
        .o_pkt       (pkt),
        .o_pkt_valid (valid),
        .i_pkt_ready (ready),
        .o_frame_err (frameErr),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (valid && ready) begin
                acceptSeen++;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_packet actual=0x%0h expected=none", pkt);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("packet", pkt, popped);
                end
            end
            if (frameErr) errSeen++;
            if (overrun)  ovrSeen++;
        end
    end

    function automatic bit parOf(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Reference model: frame rules evaluated on whole bytes.
    task automatic modelFrame(input logic [7:0] data, input bit par, input bit stop);
        logic [31:0] p;
        if (($countones({data, par}) % 2 != 1) || !stop) begin
            errExp++;
            cur.delete();
        end else if (cur.size() == 0 && !data[3]) begin
            errExp++;
        end else begin
            cur.push_back(data);
            if (cur.size() == W) begin
                p = '0;
                for (int i = 0; i < W; i++) p = (p << 8) | 32'(cur[i]);
                cur.delete();
                if (holding) ovrExp++;
                else begin
                    expQ.push_back(p);
                    if (!ready) holding = 1'b1;
                end
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input bit b, input int half, input bit glitch);
        ps2Data = b;
        if (glitch) begin
            waitCycles(2);
            ps2Clk = 1'b0;
            waitCycles(FILT - 1);
            ps2Clk = 1'b1;
            waitCycles(half - 1 - FILT);
        end else begin
            waitCycles(half);
        end
        ps2Clk = 1'b0;
        waitCycles(half);
        ps2Clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit par, input bit stop,
                                 input int half, input int glitchBit);
        logic [10:0] frame;
        frame = {stop, par, data, 1'b0};
        modelFrame(data, par, stop);
        for (int i = 0; i < 11; i++) sendBit(frame[i], half, i == glitchBit);
        ps2Data = 1'b1;
        waitCycles(20);
    endtask

    task automatic sendGood(input logic [7:0] data);
        applyStimulus(data, parOf(data), 1'b1, 12, -1);
    endtask

    task automatic sendPacket(input logic [31:0] p);
        for (int i = 0; i < W; i++) sendGood(p[31-8*i -: 8]);
    endtask

    task automatic sendPartial(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) sendBit(frame[i], 12, 1'b0);
    endtask

    task automatic checkpoint(input string tag);
        waitCycles(40);
        checkOutput({tag, "_errs"}, 32'(errSeen), 32'(errExp));
        checkOutput({tag, "_overruns"}, 32'(ovrSeen), 32'(ovrExp));
        checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        logic [7:0] d;
        bit p, s;
        reset = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; ready = 1'b1;
        waitCycles(5);
        checkOutput("reset_pkt", pkt, 32'h0);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_err", 32'(frameErr), 32'h0);
        checkOutput("reset_ovr", 32'(overrun), 32'h0);
        reset = 1'b0;
        waitCycles(5);

        $display("[TB] basic packet");
        a0 = acceptSeen;
        sendPacket(32'h0812F401);
        checkpoint("t1");
        checkOutput("t1_accepts", 32'(acceptSeen - a0), 32'd1);

        $display("[TB] parity error then restart");
        sendGood(8'h08);
        applyStimulus(8'h12, 1'b0, 1'b1, 12, -1);
        sendPacket(32'h08000000);
        checkpoint("t2");

        $display("[TB] alignment error");
        sendGood(8'h00);
        sendPacket(32'h08112233);
        checkpoint("t3");

        $display("[TB] timeout resync");
        sendGood(8'h08);
        sendPartial({1'b1, 1'b0, 8'h5A, 1'b0}, 6);
        waitCycles(TO + 10);
        cur.delete();
        sendPacket(32'h8C3C0F18);
        checkpoint("t4");

        $display("[TB] backpressure and overrun");
        ready = 1'b0;
        sendPacket(32'h1B2B3B4B);
        waitCycles(40);
        checkOutput("t5_valid", 32'(valid), 32'h1);
        checkOutput("t5_held1", pkt, 32'h1B2B3B4B);
        sendPacket(32'h2F445566);
        waitCycles(40);
        checkOutput("t5_held2", pkt, 32'h1B2B3B4B);
        checkOutput("t5_overrun", 32'(ovrSeen), 32'(ovrExp));
        @(posedge clk); #1;
        ready = 1'b1;
        holding = 1'b0;
        @(negedge clk);
        checkOutput("t5_valid_at_accept", 32'(valid), 32'h1);
        @(negedge clk);
        checkOutput("t5_valid_drop", 32'(valid), 32'h0);
        checkpoint("t5");

        $display("[TB] glitch and mid-frame reset");
        sendGood(8'h9E);
        applyStimulus(8'h01, parOf(8'h01), 1'b1, 12, 5);
        sendGood(8'h02);
        sendGood(8'h03);
        checkpoint("t6a");
        sendGood(8'h08);
        sendPartial({1'b1, 1'b0, 8'hFF, 1'b0}, 4);
        reset = 1'b1;
        cur.delete();
        waitCycles(3);
        checkOutput("t6_rst_pkt", pkt, 32'h0);
        checkOutput("t6_rst_valid", 32'(valid), 32'h0);
        checkOutput("t6_rst_err", 32'(frameErr), 32'h0);
        checkOutput("t6_rst_ovr", 32'(overrun), 32'h0);
        ps2Data = 1'b1;
        reset = 1'b0;
        waitCycles(10);
        sendPacket(32'h4A1E2D3C);
        checkpoint("t6b");

        $display("[TB] randomized frames");
        for (int i = 0; i < 60; i++) begin
            d = 8'($urandom);
            if ($urandom_range(9) < 7) d[3] = 1'b1;
            p = parOf(d);
            if ($urandom_range(11) == 0) p = ~p;
            s = ($urandom_range(12) != 0);
            applyStimulus(d, p, s, $urandom_range(10, 16), -1);
        end
        checkpoint("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
